// File: rtl/assoc_cache_pkg.sv
// Shared definitions for assoc_cache: default parameters, address field widths,
// the per-way age type and the enums used by the cache and its LRU helper.
package assoc_cache_pkg;

   localparam int unsigned DEF_WAYS           = 4;
   localparam int unsigned DEF_SETS           = 64;
   localparam int unsigned DEF_WORD_LEN       = 32;
   localparam int unsigned DEF_WORDS_PER_LINE = 2;
   localparam int unsigned DEF_ADDR_LEN       = 17;

   // Wide enough for WAYS up to 8; only values 0..WAYS-1 are ever stored.
   localparam int unsigned AGE_W = 3;
   typedef logic [AGE_W-1:0] age_t;

   typedef enum logic {LRU_TOUCH, LRU_INVAL} lru_op_e;
   typedef enum logic {ST_IDLE, ST_FLUSH} flush_st_e;

   function automatic int unsigned word_bits(int unsigned words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int unsigned set_bits(int unsigned sets);
      return $clog2(sets);
   endfunction

   function automatic int unsigned tag_bits(int unsigned addr_len, int unsigned sets,
                                            int unsigned words_per_line);
      return addr_len - $clog2(sets) - $clog2(words_per_line);
   endfunction

endpackage

// File: rtl/assoc_cache_if.sv
// Request/response bundle of assoc_cache; master drives requests, slave is the cache.
// Counter signals exist only when CACHE_STATS_EN is defined.
interface assoc_cache_if
   import assoc_cache_pkg::*;
#(
   parameter int unsigned WORD_LEN       = DEF_WORD_LEN,
   parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
   parameter int unsigned ADDR_LEN       = DEF_ADDR_LEN
) ();

   logic [ADDR_LEN-1:0]                address;
   logic [WORD_LEN*WORDS_PER_LINE-1:0] write_data;
   logic                               cache_read_en;
   logic                               cache_write_en;
   logic                               invalidate;
   logic                               flush;
   logic [WORD_LEN-1:0]                read_data;
   logic                               hit;
   logic                               busy;
`ifdef CACHE_STATS_EN
   logic [31:0]                        hit_count;
   logic [31:0]                        miss_count;
`endif

   modport master (
      output address, write_data, cache_read_en, cache_write_en, invalidate, flush,
      input  read_data, hit, busy
`ifdef CACHE_STATS_EN
      , input hit_count, miss_count
`endif
   );

   modport slave (
      input  address, write_data, cache_read_en, cache_write_en, invalidate, flush,
      output read_data, hit, busy
`ifdef CACHE_STATS_EN
      , output hit_count, miss_count
`endif
   );

endinterface

// File: rtl/assoc_cache_lru_set.sv
// Combinational true-LRU update for one set: touch or invalidate a way,
// returning the next ages and the current victim (age WAYS-1).
module cache_lru_set
   import assoc_cache_pkg::*;
#(
   parameter int unsigned WAYS = DEF_WAYS
) (
   input  age_t                    ages_i [WAYS],
   input  logic [$clog2(WAYS)-1:0] way_i,
   input  lru_op_e                 op_i,
   output age_t                    ages_o [WAYS],
   output logic [$clog2(WAYS)-1:0] victim_o
);

   localparam int unsigned WAY_W = $clog2(WAYS);

   age_t ref_age;

   always_comb begin
      ref_age  = ages_i[way_i];
      victim_o = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         ages_o[w] = ages_i[w];
         if (ages_i[w] == age_t'(WAYS-1)) victim_o = WAY_W'(w);
         if (op_i == LRU_TOUCH) begin
            if (WAY_W'(w) == way_i)        ages_o[w] = '0;
            else if (ages_i[w] < ref_age)  ages_o[w] = ages_i[w] + age_t'(1);
         end else begin
            if (WAY_W'(w) == way_i)        ages_o[w] = age_t'(WAYS-1);
            else if (ages_i[w] > ref_age)  ages_o[w] = ages_i[w] - age_t'(1);
         end
      end
   end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative cache with combinational lookup, true-LRU replacement and a
// one-set-per-cycle flush engine. Define CACHE_STATS_EN for hit/miss counters.
module assoc_cache
   import assoc_cache_pkg::*;
#(
   parameter int unsigned WAYS           = DEF_WAYS,
   parameter int unsigned SETS           = DEF_SETS,
   parameter int unsigned WORD_LEN       = DEF_WORD_LEN,
   parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
   parameter int unsigned ADDR_LEN       = DEF_ADDR_LEN
) (
   input logic          clk,
   input logic          rst,
   assoc_cache_if.slave bus
);

   localparam int unsigned WW     = word_bits(WORDS_PER_LINE);
   localparam int unsigned SW     = set_bits(SETS);
   localparam int unsigned TW     = tag_bits(ADDR_LEN, SETS, WORDS_PER_LINE);
   localparam int unsigned WAY_W  = $clog2(WAYS);
   localparam int unsigned LINE_W = WORD_LEN * WORDS_PER_LINE;

   logic              valid_q [SETS][WAYS];
   age_t              age_q   [SETS][WAYS];
   logic [TW-1:0]     tag_q   [SETS][WAYS];
   logic [LINE_W-1:0] data_q  [SETS][WAYS];

   flush_st_e     state_q, state_d;
   logic [SW-1:0] fcnt_q, fcnt_d;
   logic          busy;

   logic [TW-1:0]    req_tag;
   logic [SW-1:0]    req_set;
   logic [WW-1:0]    req_word;
   logic             hit_raw, inv_found;
   logic [WAY_W-1:0] hit_way, inv_way, victim, fill_way, lru_way;
   logic             accept, do_fill, do_inval, do_rd;
   lru_op_e          lru_op;
   age_t             set_ages [WAYS];
   age_t             lru_ages [WAYS];

   assign {req_tag, req_set, req_word} = bus.address;

   always_comb begin
      hit_raw   = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         set_ages[w] = age_q[req_set][w];
         if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag && !hit_raw) begin
            hit_raw = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[req_set][w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
   end

   // A flush pulse or an active flush swallows every other request that cycle.
   always_comb begin
      accept   = (state_q == ST_IDLE) && !bus.flush;
      do_fill  = accept && bus.cache_write_en;
      do_inval = accept && !bus.cache_write_en && bus.invalidate && hit_raw;
      do_rd    = accept && !bus.cache_write_en && !bus.invalidate && bus.cache_read_en && hit_raw;
      fill_way = hit_raw ? hit_way : (inv_found ? inv_way : victim);
      lru_way  = do_fill ? fill_way : hit_way;
      lru_op   = do_inval ? LRU_INVAL : LRU_TOUCH;
   end

   cache_lru_set #(.WAYS(WAYS)) u_lru (
      .ages_i   (set_ages),
      .way_i    (lru_way),
      .op_i     (lru_op),
      .ages_o   (lru_ages),
      .victim_o (victim)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         ST_IDLE: if (bus.flush) begin
            state_d = ST_FLUSH;
            fcnt_d  = '0;
         end
         ST_FLUSH: begin
            fcnt_d = fcnt_q + SW'(1);
            if (fcnt_q == SW'(SETS-1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q == ST_FLUSH);
      bus.busy      = busy;
      bus.hit       = hit_raw && !busy;
      bus.read_data = '0;
      if (hit_raw && !busy)
         bus.read_data = data_q[req_set][hit_way][req_word*WORD_LEN +: WORD_LEN];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned s = 0; s < SETS; s++)
            for (int unsigned w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               age_q[s][w]   <= age_t'(w);
            end
      end else if (busy) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            valid_q[fcnt_q][w] <= 1'b0;
            age_q[fcnt_q][w]   <= age_t'(w);
         end
      end else begin
         if (do_fill)       valid_q[req_set][fill_way] <= 1'b1;
         else if (do_inval) valid_q[req_set][hit_way]  <= 1'b0;
         if (do_fill || do_inval || do_rd)
            for (int unsigned w = 0; w < WAYS; w++) age_q[req_set][w] <= lru_ages[w];
      end
   end

   always_ff @(posedge clk) begin
      if (do_fill) begin
         tag_q[req_set][fill_way]  <= req_tag;
         data_q[req_set][fill_way] <= bus.write_data;
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] hit_count_q, miss_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else if (!busy && bus.cache_read_en) begin
         if (hit_raw) begin
            if (hit_count_q != '1) hit_count_q <= hit_count_q + 32'd1;
         end else begin
            if (miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
         end
      end
   end

   assign bus.hit_count  = hit_count_q;
   assign bus.miss_count = miss_count_q;
`endif

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter WAYS, 4, associativity; SHALL be a power of two, 2..8.
REQ-002 Parameter SETS, 64, number of sets; SHALL be a power of two.
REQ-003 Parameter WORD_LEN, 32, data word width in bits.
REQ-004 Parameter WORDS_PER_LINE, 2, words per line; SHALL be a power of two, at least 2.
REQ-005 Parameter ADDR_LEN, 17, address width; tag width SHALL be ADDR_LEN - log2(SETS) - log2(WORDS_PER_LINE).
REQ-006 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 address  in  ADDR_LEN  split as {tag, set, word}, with word in the LSBs.
REQ-009 write_data  in  WORD_LEN*WORDS_PER_LINE  fill line; word 0 is in the LSBs.
REQ-010 cache_read_en  in  1  lookup qualifier; a hit updates replacement state.
REQ-011 cache_write_en  in  1  line fill request.
REQ-012 invalidate  in  1  invalidate the hitting line.
REQ-013 flush  in  1  single-cycle pulse that starts a clear of all sets.
REQ-014 read_data  out  WORD_LEN  selected word of the hitting way; 0 when there is no hit.
REQ-015 hit  out  1  combinational tag match on a valid way; forced 0 while busy.
REQ-016 busy  out  1  flush in progress.
REQ-017 hit_count, miss_count  out  32 each  statistics counters; present only under REQ-031.

Function
REQ-018 Lookup SHALL be combinational: hit and read_data are valid in the same cycle as address; no latency.
REQ-019 Replacement SHALL be true LRU using per-way log2(WAYS)-bit ages per set; age 0 is most recent and age WAYS-1 is the victim.
REQ-020 On access to way w, every way in the set with age < age[w] SHALL increment, and age[w] SHALL become 0; ages always remain a permutation of 0..WAYS-1.
REQ-021 An access SHALL be any of: a read hit with cache_read_en, a fill, or an invalidate hit.
REQ-022 Fill target SHALL be chosen in this order: the way already holding the tag (overwrite, never duplicate), else the lowest-index invalid way, else the age-WAYS-1 way; the target gets the tag, the data and valid=1, and is touched.
REQ-023 Invalidate with hit SHALL clear that way's valid bit and set its age to WAYS-1; all other ages with age > old age SHALL decrement.
REQ-024 Invalidate without a hit SHALL have no effect.
REQ-025 Same-cycle priority SHALL be: flush/busy > fill > invalidate > read LRU update; the lower-priority operations are dropped.
REQ-026 Flush SHALL clear one set per cycle, starting at set 0, for SETS cycles.
  - busy SHALL be high from the cycle after the flush pulse until the last set is cleared.
  - All other requests SHALL be ignored while busy.
  - A flush pulse while busy SHALL be ignored.
REQ-027 Flush SHALL clear the valid bits and restore ages to the reset ordering; data and tags are unchanged.

Reset
REQ-028 rst SHALL asynchronously clear all valid bits, set age[w]=w in every set, clear busy and the flush counter, and zero hit_count and miss_count.
REQ-029 rst during a flush SHALL abort it; busy is 0 on the next edge.
REQ-030 Data and tag arrays SHALL not be reset.

Configuration
REQ-031 With CACHE_STATS_EN defined, the statistics counters SHALL be present:
  - hit_count SHALL increment on each non-busy cycle with cache_read_en and hit.
  - miss_count SHALL increment on each non-busy cycle with cache_read_en and no hit.
  - Both counters SHALL saturate at 2^32-1.
REQ-032 Without CACHE_STATS_EN, the counter ports and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Default parameter values, the address field width functions, and the age type SHALL live in the shared defines package.
REQ-034 Replacement logic SHALL be one sub-module, cache_lru_set. It takes the ages for one set, the touched way and the op (touch or invalidate), and returns the next ages and the victim way; it is combinational.

Verification
REQ-035 Reset, then read tag 5 / set 3 -> hit=0, read_data=0, miss_count=1.
REQ-036 Fill tags 1,2,3,4 into set 0, then read tag 1 and fill tag 9 -> tag 2 is evicted; tag 1 still hits.
REQ-037 Fill tag 7 into set 2 with write_data {0xBBBBBBBB, 0xAAAAAAAA}; read word 0 -> 0xAAAAAAAA and word 1 -> 0xBBBBBBBB, with hit=1 in the same cycle.
REQ-038 Fill tag 7 into set 2 twice with different data -> one valid way, holding the second data.
REQ-039 Fill and invalidate in the same cycle on a hitting address -> fill wins and the line stays valid; a following invalidate -> hit=0, and the next fill to that set reuses the freed way.
REQ-040 Flush pulse -> busy high for exactly 64 cycles and all lookups miss; rst asserted at cycle 10 of the flush -> busy=0 at once, and the flush is not resumed.
